// File: rtl/dc_offset_removal_mc.sv
// Multi-channel DC offset remover.
// One sample set (one word per channel) is accepted at a time. The channels
// are then walked serially through a single subtract/saturate/EMA datapath.
// Per-channel DC estimates live in signed W+K+1 bit accumulators whose
// value is acc >>> K. Modes: track, freeze, bypass, clear.
module dc_offset_removal_mc #(
   parameter int W         = 14,
   parameter int CH        = 3,
   parameter int K         = 10,
   parameter int WARM_LOG2 = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CH*W-1:0] in_data,
   input  logic [1:0]      mode,
   output logic            out_valid,
   output logic [CH*W-1:0] out_data,
   output logic [CH*W-1:0] dc_est,
   output logic            settled,
   output logic            overrun
);

   localparam int AW = W + K + 1;
   localparam int IW = (CH > 1) ? $clog2(CH) : 1;
   localparam int CW = WARM_LOG2 + 1;

   localparam logic [IW-1:0] IDX_LAST = IW'(CH - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] WARM_MAX = {1'b1, {WARM_LOG2{1'b0}}};

   localparam logic [1:0] MODE_TRACK  = 2'b00;
   localparam logic [1:0] MODE_FREEZE = 2'b01;
   localparam logic [1:0] MODE_BYPASS = 2'b10;
   localparam logic [1:0] MODE_CLEAR  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PROC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Clamp a W+1 bit difference into the signed W-bit range.
   function automatic logic [W-1:0] sat_w(input logic [W:0] d);
      logic [W-1:0] r;
      if (d[W] != d[W-1]) begin
         r = d[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         r = d[W-1:0];
      end
      return r;
   endfunction

   // DC estimate of one accumulator: arithmetic shift, truncated to W bits.
   function automatic logic [W-1:0] dc_of(input logic signed [AW-1:0] a);
      return W'(a >>> K);
   endfunction

   state_t                 state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [CH*W-1:0]        x_q, x_d;
   logic [1:0]             mode_q, mode_d;
   logic signed [AW-1:0]   acc_q [CH];
   logic signed [AW-1:0]   acc_d [CH];
   logic [CH*W-1:0]        out_data_q, out_data_d;
   logic [CH*W-1:0]        dc_est_q, dc_est_d;
   logic                   out_valid_q, out_valid_d;
   logic                   in_ready_q, in_ready_d;
   logic [CW-1:0]          warm_cnt_q, warm_cnt_d;
   logic                   settled_q, settled_d;
   logic                   overrun_q, overrun_d;

   logic [W-1:0]           x_cur;
   logic signed [AW-1:0]   acc_cur;
   logic [W-1:0]           dc_cur;
   logic [W:0]             diff;
   logic [W-1:0]           y_cur;

   // Shared channel datapath: select channel idx, subtract its DC, pick output.
   always_comb begin
      x_cur   = x_q[idx_q*W +: W];
      acc_cur = acc_q[idx_q];
      dc_cur  = dc_of(acc_cur);
      diff    = {x_cur[W-1], x_cur} - {dc_cur[W-1], dc_cur};
      if ((mode_q == MODE_TRACK) || (mode_q == MODE_FREEZE)) begin
         y_cur = sat_w(diff);
      end else begin
         y_cur = x_cur;
      end
   end

   // Next-state logic: handshake FSM, per-channel update, warm-up and overrun.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      x_d        = x_q;
      mode_d     = mode_q;
      acc_d      = acc_q;
      out_data_d = out_data_q;
      dc_est_d   = dc_est_q;
      warm_cnt_d = warm_cnt_q;
      overrun_d  = overrun_q;

      if (in_valid && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d     = in_data;
               mode_d  = mode;
               idx_d   = '0;
               state_d = S_PROC;
               case (mode)
                  MODE_TRACK: begin
                     if (warm_cnt_q != WARM_MAX) begin
                        warm_cnt_d = warm_cnt_q + CNT_ONE;
                     end else begin
                        warm_cnt_d = warm_cnt_q;
                     end
                  end
                  MODE_CLEAR: begin
                     warm_cnt_d = '0;
                     overrun_d  = 1'b0;
                  end
                  default: begin
                     warm_cnt_d = warm_cnt_q;
                  end
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PROC: begin
            out_data_d[idx_q*W +: W] = y_cur;
            case (mode_q)
               MODE_TRACK:  acc_d[idx_q] = acc_cur + {{K{diff[W]}}, diff};
               MODE_CLEAR:  acc_d[idx_q] = '0;
               default:     acc_d[idx_q] = acc_cur;
            endcase
            dc_est_d[idx_q*W +: W] = dc_of(acc_d[idx_q]);
            if (idx_q == IDX_LAST) begin
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IDX_ONE;
               state_d = S_PROC;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      settled_d   = (warm_cnt_d == WARM_MAX);
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   // State and output registers; reset aborts any set in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         x_q         <= '0;
         mode_q      <= MODE_TRACK;
         acc_q       <= '{default: '0};
         out_data_q  <= '0;
         dc_est_q    <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         warm_cnt_q  <= '0;
         settled_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         x_q         <= x_d;
         mode_q      <= mode_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         dc_est_q    <= dc_est_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         warm_cnt_q  <= warm_cnt_d;
         settled_q   <= settled_d;
         overrun_q   <= overrun_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign dc_est    = dc_est_q;
   assign settled   = settled_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_dc_offset_removal_mc.sv
// Directed bench for dc_offset_removal_mc (W=14, CH=3, K=4, WARM_LOG2=4).
// A set accepted at edge 0 produces out_valid after edge 3; the block is
// ready again after edge 4, so a held in_valid is accepted every 5 edges.
module tb_dc_offset_removal_mc;

   localparam int W  = 14;
   localparam int CH = 3;
   localparam int K  = 4;
   localparam int WL = 4;

   localparam logic [1:0] M_TRACK  = 2'b00;
   localparam logic [1:0] M_FREEZE = 2'b01;
   localparam logic [1:0] M_BYPASS = 2'b10;
   localparam logic [1:0] M_CLEAR  = 2'b11;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [CH*W-1:0] in_data;
   logic [1:0]      mode;
   logic            out_valid;
   logic [CH*W-1:0] out_data;
   logic [CH*W-1:0] dc_est;
   logic            settled;
   logic            overrun;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dc_offset_removal_mc #(.W(W), .CH(CH), .K(K), .WARM_LOG2(WL)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .mode(mode), .out_valid(out_valid),
      .out_data(out_data), .dc_est(dc_est), .settled(settled),
      .overrun(overrun)
   );

   task automatic check(input string tag, input logic signed [31:0] observed,
                        input logic signed [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic logic signed [W-1:0] sl(input logic [CH*W-1:0] bus, input int i);
      return bus[i*W +: W];
   endfunction

   function automatic logic [CH*W-1:0] pack3(input int a, input int b, input int c);
      logic [W-1:0] ta, tb, tc;
      ta = W'(a);
      tb = W'(b);
      tc = W'(c);
      return {tc, tb, ta};
   endfunction

   task automatic check3(input string tag, input logic [CH*W-1:0] bus,
                         input int e0, input int e1, input int e2);
      check($sformatf("%s[0]", tag), sl(bus, 0), e0);
      check($sformatf("%s[1]", tag), sl(bus, 1), e1);
      check($sformatf("%s[2]", tag), sl(bus, 2), e2);
   endtask

   // Offer one set, scramble the inputs after accept, wait for its result.
   task automatic run_set(input logic [CH*W-1:0] data, input logic [1:0] md);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", in_ready, 1);
      in_valid = 1'b1;
      in_data  = data;
      mode     = md;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = (CH*W)'({$urandom(), $urandom()});
      mode     = 2'($urandom());
      n = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_wait", out_valid, 1);
   endtask

   // Hard stop in case something never finishes.
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [W-1:0] v;
      int n;

      // ---- reset with random inputs ----
      rst = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      mode = M_TRACK;
      repeat (3) begin
         @(negedge clk);
         in_valid = 1'($urandom());
         in_data  = (CH*W)'({$urandom(), $urandom()});
         mode     = 2'($urandom());
      end
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check3("rst_out_data", out_data, 0, 0, 0);
      check3("rst_dc_est", dc_est, 0, 0, 0);
      check("rst_settled", settled, 0);
      check("rst_overrun", overrun, 0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      // ---- convergence on constant 1000 ----
      for (int s = 1; s <= 200; s++) begin
         run_set(pack3(1000, 1000, 1000), M_TRACK);
         if (s == 1) begin
            check3("conv_out1", out_data, 1000, 1000, 1000);
            check3("conv_dc1", dc_est, 62, 62, 62);
         end
         if (s == 2) check3("conv_out2", out_data, 938, 938, 938);
         if (s == 15) check("settled_15", settled, 0);
         if (s == 16) check("settled_16", settled, 1);
         if (s == 200) begin
            for (int i = 0; i < CH; i++) begin
               v = sl(out_data, i);
               check($sformatf("conv_abs15[%0d]", i), ((v <= 15) && (v >= -15)), 1);
            end
            check3("conv_out200", out_data, 0, 0, 0);
            check3("conv_dc200", dc_est, 1000, 1000, 1000);
         end
      end

      // ---- bypass ----
      run_set(pack3(123, 123, 123), M_BYPASS);
      check3("byp_out", out_data, 123, 123, 123);
      check3("byp_dc", dc_est, 1000, 1000, 1000);
      check("byp_settled", settled, 1);

      // ---- clear ----
      run_set(pack3(123, 123, 123), M_CLEAR);
      check3("clr_out", out_data, 123, 123, 123);
      check3("clr_dc", dc_est, 0, 0, 0);
      check("clr_settled", settled, 0);
      check("clr_overrun", overrun, 0);

      // ---- distinct channels incl. negative full scale ----
      run_set(pack3(500, -100, -8192), M_TRACK);
      check3("mix_out1", out_data, 500, -100, -8192);
      check3("mix_dc1", dc_est, 31, -7, -512);
      run_set(pack3(500, -100, -8192), M_TRACK);
      check3("mix_out2", out_data, 469, -93, -7680);
      check3("mix_dc2", dc_est, 60, -13, -992);

      // ---- saturation ----
      run_set(pack3(0, 0, 0), M_CLEAR);
      for (int s = 1; s <= 300; s++) begin
         run_set(pack3(8000, 8000, 8000), M_TRACK);
      end
      check3("sat_out300", out_data, 0, 0, 0);
      check3("sat_dc300", dc_est, 8000, 8000, 8000);
      check("sat_settled", settled, 1);
      run_set(pack3(-8192, -8192, -8192), M_FREEZE);
      check3("frz_out", out_data, -8192, -8192, -8192);
      check3("frz_dc", dc_est, 8000, 8000, 8000);
      check("pre_hs_overrun", overrun, 0);

      // ---- in_valid held high continuously ----
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("hs_ready_wait", in_ready, 1);
      in_valid = 1'b1;
      in_data  = pack3(8000, 8000, 8000);
      mode     = M_TRACK;
      for (int e = 0; e <= 10; e++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("hs_out_valid_e%0d", e), out_valid, ((e == 3) || (e == 8)));
         check($sformatf("hs_in_ready_e%0d", e), in_ready, ((e == 4) || (e == 9)));
         check($sformatf("hs_overrun_e%0d", e), overrun, (e >= 1));
      end
      in_valid = 1'b0;

      // ---- async reset between edges 1 and 2 of the set accepted at edge 10 ----
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("arst_in_ready", in_ready, 1);
      check("arst_out_valid", out_valid, 0);
      check3("arst_out_data", out_data, 0, 0, 0);
      check3("arst_dc_est", dc_est, 0, 0, 0);
      check("arst_settled", settled, 0);
      check("arst_overrun", overrun, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("abort_no_valid_%0d", c), out_valid, 0);
      end
      run_set(pack3(500, -100, -8192), M_TRACK);
      check3("post_rst_out", out_data, 500, -100, -8192);
      check3("post_rst_dc", dc_est, 31, -7, -512);

      // ---- overrun, then cleared by an accepted clear set ----
      in_valid = 1'b1;
      in_data  = pack3(123, 123, 123);
      mode     = M_CLEAR;
      @(posedge clk);
      @(negedge clk);
      check("ovr_set", overrun, 1);
      check("ovr_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ovr_clr_wait", out_valid, 1);
      check3("ovr_clr_out", out_data, 123, 123, 123);
      check3("ovr_clr_dc", dc_est, 0, 0, 0);
      check("ovr_clr_overrun", overrun, 0);
      check("ovr_clr_settled", settled, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
